dmem_responder: RTL and testbench

Memory-side responder for the CortexM0 data port. It accepts DREQ/DADDR/DRW/DSIZE/write-data requests from the core and drives SRAM port 2 (chip select, word address, write enable, byte enables, data). It returns lane-aligned read data with a valid strobe and a ready handshake. Misaligned and out-of-range accesses are flagged, and the first faulting address is held sticky.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and request-decode helpers for the CortexM0 data-port responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } state_t;

    function automatic logic [3:0] byte_enables(input logic [1:0] offset, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Alignment to the access size plus an all-zero address tail above the SRAM window.
    function automatic logic legal_req(input logic [31:0] addr, input logic [1:0] size,
                                       input int unsigned aw);
        logic aligned;
        case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            SZ_WORD: aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned && ((addr >> (aw + 32'd2)) == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: write-data replication onto all lanes and read-data
// extraction (right-justify + zero-extend, or raw word when ZEXT=0).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int ZEXT = 1
) (
    input  logic [31:0] wdata,
    input  logic [1:0]  wsize,
    output logic [31:0] wdata_rep,
    input  logic [31:0] rdata_raw,
    input  logic [1:0]  rsize,
    input  logic [1:0]  roffset,
    output logic [31:0] rdata_out
);
    logic [31:0] shifted_s;

    assign shifted_s = rdata_raw >> {roffset, 3'b000};

    // Replicate the sub-word so the SRAM byte enables pick the right lane.
    always_comb begin
        wdata_rep = wdata;
        case (wsize)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    // Select extracted or raw read data.
    always_comb begin
        rdata_out = rdata_raw;
        if (ZEXT != 0) begin
            case (rsize)
                SZ_BYTE: rdata_out = {24'd0, shifted_s[7:0]};
                SZ_HALF: rdata_out = {16'd0, shifted_s[15:0]};
                default: rdata_out = shifted_s;
            endcase
        end else begin
            rdata_out = rdata_raw;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// CortexM0 data-port responder driving one synchronous SRAM port.
// Writes complete in the accept cycle; reads wait MEM_LAT cycles in RWAIT.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW      = 12,
    parameter int MEM_LAT = 1,
    parameter int ZEXT    = 1
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          DREQ,
    input  logic [31:0]   DADDR,
    input  logic          DRW,
    input  logic [1:0]    DSIZE,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    output logic          DRVALID,
    output logic          DREADY,
    output logic          DFAULT,
    output logic [31:0]   FAULT_ADDR,
    output logic          FAULT_VLD,
    input  logic          FAULT_CLR,
    output logic          M_CSN,
    output logic [AW-1:0] M_ADDR,
    output logic          M_WE,
    output logic [3:0]    M_BE,
    output logic [31:0]   M_DI,
    input  logic [31:0]   M_DO
);
    localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

    state_t        state_r;
    logic [1:0]    cnt_r;
    logic [AW-1:0] raddr_r;
    logic [3:0]    rbe_r;
    logic [1:0]    rsize_r;
    logic [1:0]    roff_r;
    logic [31:0]   drdata_r;
    logic          drvalid_r;
    logic          dready_r;
    logic          dfault_r;
    logic [31:0]   fault_addr_r;
    logic          fault_vld_r;

    logic          accept_s;
    logic          legal_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_rep_s;
    logic [31:0]   rdata_s;
    logic          m_csn_s;
    logic          m_we_s;
    logic [3:0]    m_be_s;
    logic [AW-1:0] m_addr_s;

    assign accept_s = DREQ & dready_r;
    assign legal_s  = legal_req(DADDR, DSIZE, AW);
    assign be_s     = byte_enables(DADDR[1:0], DSIZE);

    dmem_lane_align #(.ZEXT(ZEXT)) u_lane_align (
        .wdata     (DWDATA),
        .wsize     (DSIZE),
        .wdata_rep (wdata_rep_s),
        .rdata_raw (M_DO),
        .rsize     (rsize_r),
        .roffset   (roff_r),
        .rdata_out (rdata_s)
    );

    // SRAM drive: live request in IDLE, registered read address while waiting.
    always_comb begin
        m_csn_s  = 1'b1;
        m_we_s   = 1'b0;
        m_be_s   = 4'b0000;
        m_addr_s = DADDR[AW+1:2];
        if (state_r == RWAIT) begin
            m_csn_s  = 1'b0;
            m_addr_s = raddr_r;
            m_be_s   = rbe_r;
        end else if (accept_s && legal_s) begin
            m_csn_s = 1'b0;
            m_we_s  = DRW;
            m_be_s  = be_s;
        end else begin
            m_csn_s = 1'b1;
        end
    end

    // Request FSM, read-data return and sticky fault capture.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            raddr_r      <= '0;
            rbe_r        <= 4'b0000;
            rsize_r      <= 2'b00;
            roff_r       <= 2'b00;
            drdata_r     <= 32'd0;
            drvalid_r    <= 1'b0;
            dready_r     <= 1'b1;
            dfault_r     <= 1'b0;
            fault_addr_r <= 32'd0;
            fault_vld_r  <= 1'b0;
        end else begin
            drvalid_r <= 1'b0;
            dfault_r  <= 1'b0;
            // A clear in the same cycle as a new fault suppresses the capture.
            if (FAULT_CLR) begin
                fault_vld_r  <= 1'b0;
                fault_addr_r <= 32'd0;
            end else if (accept_s && !legal_s && !fault_vld_r) begin
                fault_vld_r  <= 1'b1;
                fault_addr_r <= DADDR;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s && !legal_s) begin
                        dfault_r <= 1'b1;
                        if (!DRW) begin
                            drvalid_r <= 1'b1;
                            drdata_r  <= 32'd0;
                        end
                    end else if (accept_s && !DRW) begin
                        state_r  <= RWAIT;
                        dready_r <= 1'b0;
                        cnt_r    <= CNT_LOAD;
                        raddr_r  <= DADDR[AW+1:2];
                        rbe_r    <= be_s;
                        rsize_r  <= DSIZE;
                        roff_r   <= DADDR[1:0];
                    end
                end
                RWAIT: begin
                    if (cnt_r == 2'd0) begin
                        drdata_r  <= rdata_s;
                        drvalid_r <= 1'b1;
                        dready_r  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    dready_r <= 1'b1;
                end
            endcase
        end
    end

    assign DRDATA     = drdata_r;
    assign DRVALID    = drvalid_r;
    assign DREADY     = dready_r;
    assign DFAULT     = dfault_r;
    assign FAULT_ADDR = fault_addr_r;
    assign FAULT_VLD  = fault_vld_r;
    assign M_CSN      = m_csn_s;
    assign M_WE       = m_we_s;
    assign M_BE       = m_be_s;
    assign M_ADDR     = m_addr_s;
    assign M_DI       = wdata_rep_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (zero-extend and raw) share one request stream,
// each with its own SRAM model, checked against a byte-array reference memory.
module tb_dmem_responder;
    localparam int AW      = 12;
    localparam int MEM_LAT = 3;
    localparam int NBYTES  = 4 << AW;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        DREQ = 1'b0;
    logic        DRW = 1'b0;
    logic        FAULT_CLR = 1'b0;
    logic [31:0] DADDR = 32'd0;
    logic [31:0] DWDATA = 32'd0;
    logic [1:0]  DSIZE = 2'd0;

    logic [31:0]   drdata [2];
    logic          drvalid [2];
    logic          dready [2];
    logic          dfault [2];
    logic          fault_vld [2];
    logic [31:0]   fault_addr [2];
    logic          m_csn [2];
    logic          m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [3:0]    m_be [2];
    logic [31:0]   m_di [2];
    logic [31:0]   m_do [2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    logic [7:0]    ref_bytes [NBYTES];
    exp_t          q0 [$];
    exp_t          q1 [$];
    exp_t          e0, e1;
    int            rd_done = 0;
    int            fault_cyc = -1;
    logic          fvld_m = 1'b0;
    logic [31:0]   faddr_m = 32'd0;
    logic [AW-1:0] hold_addr = '0;
    logic [3:0]    hold_be = 4'd0;

    dmem_responder #(.AW(AW), .MEM_LAT(MEM_LAT), .ZEXT(1)) u_dut_zext (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE),
        .DWDATA(DWDATA), .DRDATA(drdata[0]), .DRVALID(drvalid[0]), .DREADY(dready[0]),
        .DFAULT(dfault[0]), .FAULT_ADDR(fault_addr[0]), .FAULT_VLD(fault_vld[0]),
        .FAULT_CLR(FAULT_CLR), .M_CSN(m_csn[0]), .M_ADDR(m_addr[0]), .M_WE(m_we[0]),
        .M_BE(m_be[0]), .M_DI(m_di[0]), .M_DO(m_do[0])
    );

    dmem_responder #(.AW(AW), .MEM_LAT(MEM_LAT), .ZEXT(0)) u_dut_raw (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE),
        .DWDATA(DWDATA), .DRDATA(drdata[1]), .DRVALID(drvalid[1]), .DREADY(dready[1]),
        .DFAULT(dfault[1]), .FAULT_ADDR(fault_addr[1]), .FAULT_VLD(fault_vld[1]),
        .FAULT_CLR(FAULT_CLR), .M_CSN(m_csn[1]), .M_ADDR(m_addr[1]), .M_WE(m_we[1]),
        .M_BE(m_be[1]), .M_DI(m_di[1]), .M_DO(m_do[1])
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous SRAM models: address sampled at an edge, data usable MEM_LAT edges later.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        logic [31:0] mem [4096];
        logic [31:0] pipe [MEM_LAT];
        initial begin
            for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
        end
        always @(posedge CLK) begin
            if (!m_csn[g]) begin
                if (m_we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[g][b]) mem[m_addr[g]][8*b +: 8] <= m_di[g][8*b +: 8];
                end
                pipe[0] <= mem[m_addr[g]];
            end
            for (int s = 1; s < MEM_LAT; s++) pipe[s] <= pipe[s-1];
        end
        assign m_do[g] = pipe[MEM_LAT-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Issue one request, hold it until accepted, and update the reference model.
    task automatic issue(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                         input logic [31:0] wdata, input logic clr, output int acc_cyc);
        int          n;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] di, rd, raw;
        n     = (size == 2'd3) ? 0 : (1 << size);
        legal = (size != 2'd3) && ((addr & 32'(n - 1)) == 32'd0) && (addr < 32'(NBYTES));
        be    = 4'd0;
        for (int i = 0; i < n; i++)
            if (int'(addr[1:0]) + i < 4) be[int'(addr[1:0]) + i] = 1'b1;
        di  = (n == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
              (n == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
        rd  = 32'd0;
        raw = 32'd0;
        if (legal) begin
            for (int i = 0; i < n; i++) rd |= 32'(ref_bytes[int'(addr) + i]) << (8 * i);
            for (int b = 0; b < 4; b++) raw |= 32'(ref_bytes[int'(addr & ~32'd3) + b]) << (8 * b);
        end
        DREQ = 1'b1; DADDR = addr; DRW = rw; DSIZE = size; DWDATA = wdata; FAULT_CLR = clr;
        acc_cyc = -1;
        for (int w = 0; w < 50 && acc_cyc < 0; w++) begin
            @(negedge CLK);
            if (dready[0]) begin
                if (legal) begin
                    chk("acc_csn", 32'(m_csn[0]), 32'd0);
                    chk("acc_we", 32'(m_we[0]), 32'(rw));
                    chk("acc_be", 32'(m_be[0]), 32'(be));
                    chk("acc_addr", 32'(m_addr[0]), addr >> 2);
                    if (rw) chk("wr_di", m_di[0], di);
                end else begin
                    chk("bad_csn", 32'(m_csn[0]), 32'd1);
                end
                @(posedge CLK); #1;
                acc_cyc = cyc;
                if (clr) begin
                    fvld_m = 1'b0; faddr_m = 32'd0;
                end else if (!legal && !fvld_m) begin
                    fvld_m = 1'b1; faddr_m = addr;
                end
                if (!legal) begin
                    fault_cyc = cyc;
                    if (!rw) begin
                        q0.push_back('{32'd0, cyc});
                        q1.push_back('{32'd0, cyc});
                    end
                end else if (rw) begin
                    for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
                end else begin
                    q0.push_back('{rd, cyc + MEM_LAT});
                    q1.push_back('{raw, cyc + MEM_LAT});
                    rd_done   = cyc + MEM_LAT;
                    hold_addr = addr[AW+1:2];
                    hold_be   = be;
                end
            end else begin
                @(posedge CLK); #1;
                if (clr) begin
                    fvld_m = 1'b0; faddr_m = 32'd0;
                end
            end
        end
        DREQ = 1'b0; FAULT_CLR = 1'b0;
        if (acc_cyc < 0) chk("accept_timeout", 32'(dready[0]), 32'd1);
    endtask

    task automatic fault_clear();
        FAULT_CLR = 1'b1;
        @(posedge CLK); #1;
        FAULT_CLR = 1'b0;
        fvld_m = 1'b0; faddr_m = 32'd0;
    endtask

    task automatic reset_pulse();
        RESET_N = 1'b0;
        q0.delete(); q1.delete();
        rd_done = 0; fault_cyc = -1; fvld_m = 1'b0; faddr_m = 32'd0;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk("rst_dready", 32'(dready[d]), 32'd1);
            chk("rst_csn", 32'(m_csn[d]), 32'd1);
            chk("rst_drvalid", 32'(drvalid[d]), 32'd0);
            chk("rst_drdata", drdata[d], 32'd0);
        end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
    endtask

    // Response monitor: pops the scoreboard on DRVALID and checks handshake/fault state.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (drvalid[0]) begin
                if (q0.size() == 0) chk("rvalid_zext", 32'(drvalid[0]), 32'd0);
                else begin
                    e0 = q0.pop_front();
                    chk("rdata_zext", drdata[0], e0.data);
                    chk("rvalid_cyc_zext", 32'(cyc), 32'(e0.cyc));
                end
            end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
                e0 = q0.pop_front();
                chk("rvalid_zext", 32'(drvalid[0]), 32'd1);
            end
            if (drvalid[1]) begin
                if (q1.size() == 0) chk("rvalid_raw", 32'(drvalid[1]), 32'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("rdata_raw", drdata[1], e1.data);
                    chk("rvalid_cyc_raw", 32'(cyc), 32'(e1.cyc));
                end
            end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
                e1 = q1.pop_front();
                chk("rvalid_raw", 32'(drvalid[1]), 32'd1);
            end
            for (int d = 0; d < 2; d++) begin
                chk("dready", 32'(dready[d]), 32'(cyc >= rd_done));
                chk("dfault", 32'(dfault[d]), 32'(cyc == fault_cyc));
                chk("fault_vld", 32'(fault_vld[d]), 32'(fvld_m));
                chk("fault_addr", fault_addr[d], faddr_m);
                if (cyc < rd_done) begin
                    chk("rwait_csn", 32'(m_csn[d]), 32'd0);
                    chk("rwait_we", 32'(m_we[d]), 32'd0);
                    chk("rwait_addr", 32'(m_addr[d]), 32'(hold_addr));
                    chk("rwait_be", 32'(m_be[d]), 32'(hold_be));
                end else if (!DREQ) begin
                    chk("idle_csn", 32'(m_csn[d]), 32'd1);
                    chk("idle_we", 32'(m_we[d]), 32'd0);
                    chk("idle_be", 32'(m_be[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        int c1, c2, ac, gap;
        logic [31:0] a;
        logic [1:0]  sz;
        int r;
        for (int w = 0; w < 4096; w++) begin
            for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = init_word(w) >> (8 * b);
        end
        repeat (2) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            chk("init_drdata", drdata[d], 32'd0);
            chk("init_drvalid", 32'(drvalid[d]), 32'd0);
            chk("init_dready", 32'(dready[d]), 32'd1);
            chk("init_dfault", 32'(dfault[d]), 32'd0);
            chk("init_faddr", fault_addr[d], 32'd0);
            chk("init_fvld", 32'(fault_vld[d]), 32'd0);
            chk("init_csn", 32'(m_csn[d]), 32'd1);
            chk("init_we", 32'(m_we[d]), 32'd0);
            chk("init_be", 32'(m_be[d]), 32'd0);
        end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        mon_en  = 1'b1;

        issue(32'h10, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, ac);
        issue(32'h10, 1'b0, 2'd2, 32'd0, 1'b0, ac);
        issue(32'h13, 1'b1, 2'd0, 32'h000000A5, 1'b0, ac);
        issue(32'h13, 1'b0, 2'd0, 32'd0, 1'b0, ac);
        issue(32'h10, 1'b1, 2'd2, 32'h12345678, 1'b0, ac);
        issue(32'h12, 1'b0, 2'd1, 32'd0, 1'b0, ac);

        issue(32'h21, 1'b0, 2'd1, 32'd0, 1'b0, ac);
        issue(32'h40001, 1'b0, 2'd0, 32'd0, 1'b0, ac);
        @(negedge CLK);
        chk("sticky_faddr", fault_addr[0], 32'h21);
        @(posedge CLK); #1;
        fault_clear();
        issue(32'h31, 1'b1, 2'd2, 32'h1, 1'b1, ac);
        issue(32'h33, 1'b0, 2'd3, 32'd0, 1'b0, ac);

        issue(32'h100, 1'b0, 2'd2, 32'd0, 1'b0, c1);
        issue(32'h104, 1'b0, 2'd2, 32'd0, 1'b0, c2);
        chk("b2b_accept", 32'(c2), 32'(c1 + MEM_LAT + 1));

        issue(32'h200, 1'b0, 2'd2, 32'd0, 1'b0, ac);
        reset_pulse();
        issue(32'h10, 1'b0, 2'd2, 32'd0, 1'b0, ac);

        for (int t = 0; t < 300; t++) begin
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            a  = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(14, 31));
            issue(a, 1'($urandom_range(0, 1)), sz, $urandom, 1'($urandom_range(0, 19) == 0), ac);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge CLK); #1;
            end
        end

        repeat (MEM_LAT + 4) @(posedge CLK);
        @(negedge CLK);
        chk("pending_zext", 32'(q0.size()), 32'd0);
        chk("pending_raw", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
